// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch controller.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Adds one to a four-digit packed BCD value. Returns {carry_out, result};
  // carry_out is set only when 9999 wraps to 0000. A digit at or above 9
  // always wraps to 0 so an out-of-range digit can never persist.
  function automatic logic [16:0] bcd4_inc(input logic [15:0] val);
    logic [15:0] res;
    logic        carry;
    bcd_digit_t  d;
    res   = val;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = val[4*i +: 4];
      if (carry) begin
        if (d >= BCD_MAX) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = d + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return {carry, res};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-FF synchronizer -> level debouncer -> one-cycle rising-edge pulse.
// Latency: pulse is high DEB_CYCLES+2 cycles after the first edge that samples a clean input edge.
// Backpressure: none; free-running, the pulse is never held or queued.
module btn_debounce #(
  parameter int DEB_CYCLES = 80000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

  // Accept a new level after DEB_CYCLES consecutive differing samples; pulse only on acceptance of a 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (sync_2 == level) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      level <= sync_2;
      cnt   <= '0;
      pulse <= sync_2;
    end else begin
      cnt   <= cnt + CW'(1);
      pulse <= 1'b0;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/clear stopwatch in tenths of seconds, presented as four packed BCD digits (SSS.T).
// Latency: button edge to running change DEB_CYCLES+3 cycles; first count TICK_DIV cycles after entering RUN.
// Backpressure: none; the display driver samples digits freely, upd marks each change.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV   = 800000,
  parameter int DEB_CYCLES = 80000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_ss,
  input  logic        btn_clr,
  output logic [15:0] digits,
  output logic        upd,
  output logic        running,
  output logic        ovf
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  sw_state_t     state;
  sw_state_t     state_nxt;
  logic          ss_p;
  logic          clr_p;
  logic          tick;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic [15:0]   digits_nxt;
  logic          ovf_nxt;
  logic [16:0]   inc;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ss (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_ss),
    .pulse (ss_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clr),
    .pulse (clr_p)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: clear wins over start/stop except while running, where clear is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!clr_p && ss_p) state_nxt = RUN;
      RUN:     if (ss_p) state_nxt = PAUSE;
      PAUSE: begin
        if (clr_p)     state_nxt = IDLE;
        else if (ss_p) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    running = (state == RUN);
  end

  assign tick = (state == RUN) && (presc == PRESC_LAST);
  assign inc  = bcd4_inc(digits);

  // Next prescaler, count and overflow: prescaler only advances in RUN and is zero throughout IDLE.
  always_comb begin
    presc_nxt  = presc;
    digits_nxt = digits;
    ovf_nxt    = ovf;
    case (state)
      IDLE: begin
        presc_nxt = '0;
        if (clr_p) ovf_nxt = 1'b0;
      end
      RUN: begin
        presc_nxt = tick ? '0 : presc + PW'(1);
        if (tick) begin
          digits_nxt = inc[15:0];
          if (inc[16]) ovf_nxt = 1'b1;
        end
      end
      PAUSE: begin
        if (clr_p) begin
          presc_nxt  = '0;
          digits_nxt = '0;
          ovf_nxt    = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; upd is set for the cycle after digits takes a new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc  <= '0;
      digits <= '0;
      ovf    <= 1'b0;
      upd    <= 1'b0;
    end else begin
      presc  <= presc_nxt;
      digits <= digits_nxt;
      ovf    <= ovf_nxt;
      upd    <= (digits_nxt != digits);
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with small dividers; reference model counts cycles spent running.
// Latency: n/a.
// Backpressure: n/a.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int HL       = DEB + 2;
  localparam int S_IDLE   = 0;
  localparam int S_RUN    = 1;
  localparam int S_PAUSE  = 2;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        btn_ss  = 1'b0;
  logic        btn_clr = 1'b0;
  logic [15:0] digits;
  logic        upd;
  logic        running;
  logic        ovf;

  int n_chk  = 0;
  int n_pass = 0;

  stopwatch_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .digits  (digits),
    .upd     (upd),
    .running (running),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Count value = (cycles spent running since last clear) / TICK_DIV.
  // A press is accepted when the last DEB samples, seen two cycles late, all differ from the accepted level.
  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  function automatic logic [1:0] deb_step(input logic [HL-1:0] h, input logic acc);
    logic [DEB-1:0] win;
    win = h[DEB+1:2];
    if (!acc && win == {DEB{1'b1}}) return 2'b11;
    if (acc && win == '0) return 2'b00;
    return {acc, 1'b0};
  endfunction

  int          m_state = S_IDLE;
  int          m_run   = 0;
  logic [HL-1:0] h_ss  = '0;
  logic [HL-1:0] h_clr = '0;
  logic        m_acc_ss  = 1'b0;
  logic        m_acc_clr = 1'b0;
  logic        m_ss_p    = 1'b0;
  logic        m_clr_p   = 1'b0;
  logic [15:0] m_digits  = '0;
  logic        m_upd     = 1'b0;
  logic        m_ovf     = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state <= S_IDLE; m_run <= 0; h_ss <= '0; h_clr <= '0;
      m_acc_ss <= 1'b0; m_acc_clr <= 1'b0; m_ss_p <= 1'b0; m_clr_p <= 1'b0;
      m_digits <= '0; m_upd <= 1'b0; m_ovf <= 1'b0;
    end else begin : mdl
      int          nst;
      int          nrun;
      logic [15:0] nd;
      logic [1:0]  ds;
      logic [1:0]  dc;
      nst  = m_state;
      nrun = m_run;
      if (m_state == S_RUN) nrun++;
      case (m_state)
        S_IDLE:  if (!m_clr_p && m_ss_p) nst = S_RUN;
        S_RUN:   if (m_ss_p) nst = S_PAUSE;
        default: begin
          if (m_clr_p) begin nst = S_IDLE; nrun = 0; end
          else if (m_ss_p) nst = S_RUN;
        end
      endcase
      nd = to_bcd((nrun / TICK_DIV) % 10000);
      ds = deb_step({h_ss[HL-2:0], btn_ss}, m_acc_ss);
      dc = deb_step({h_clr[HL-2:0], btn_clr}, m_acc_clr);
      m_state   <= nst;
      m_run     <= nrun;
      m_digits  <= nd;
      m_upd     <= (nd != m_digits);
      m_ovf     <= ((nrun / TICK_DIV) >= 10000);
      h_ss      <= {h_ss[HL-2:0], btn_ss};
      h_clr     <= {h_clr[HL-2:0], btn_clr};
      m_acc_ss  <= ds[1];
      m_ss_p    <= ds[0];
      m_acc_clr <= dc[1];
      m_clr_p   <= dc[0];
    end
  end

  // Per-cycle comparison against the model, plus event counters for directed checks.
  int   run_tog = 0;
  int   upd_cnt = 0;
  logic run_q   = 1'b0;
  always @(negedge clk) begin
    check("digits", digits, m_digits);
    check("upd", upd, m_upd);
    check("running", running, m_state == S_RUN);
    check("ovf", ovf, m_ovf);
    if (running !== run_q) run_tog <= run_tog + 1;
    run_q <= running;
    if (upd === 1'b1) upd_cnt <= upd_cnt + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_running(input logic v, output int lat);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc(1);
      if (running === v) begin lat = c; break; end
    end
  endtask

  task automatic wait_upd(input int budget);
    int c;
    c = 0;
    do begin cyc(1); c++; end while (upd !== 1'b1 && c < budget);
    check("upd_seen", upd, 1'b1);
  endtask

  task automatic wait_digits(input logic [15:0] v, input int budget);
    int c;
    c = 0;
    while (digits !== v && c < budget) begin cyc(1); c++; end
    check("reach_digits", digits, v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    int lat;
    int n_upd;
    int tog0;
    int u0;
    logic [15:0] frozen;

    // Reset held while buttons toggle.
    cyc(3);
    for (int i = 0; i < 8; i++) begin
      btn_ss  = i[0];
      btn_clr = ~i[0];
      cyc(1);
    end
    check("rst_digits", digits, 16'h0000);
    check("rst_upd", upd, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    btn_ss = 1'b0; btn_clr = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(8);
    check("post_rst_digits", digits, 16'h0000);
    check("post_rst_upd_cnt", upd_cnt, 0);

    // Bounce shorter than the debounce window is rejected.
    for (int k = 0; k < 5; k++) begin
      btn_ss = 1'b1; cyc(2);
      btn_ss = 1'b0; cyc(2);
    end
    cyc(6);
    check("bounce_running", running, 1'b0);
    check("bounce_toggles", run_tog, 0);

    // Clean press: running rises DEB+3 cycles after the input edge.
    btn_ss = 1'b1;
    wait_running(1'b1, lat);
    check("press_latency", lat, DEB + 3);
    btn_ss = 1'b0;
    cyc(DEB + 4);

    // A long hold yields exactly one transition (RUN -> PAUSE).
    tog0 = run_tog;
    btn_ss = 1'b1; cyc(50);
    btn_ss = 1'b0; cyc(10);
    check("hold_one_toggle", run_tog - tog0, 1);
    check("hold_paused", running, 1'b0);

    // Clear from PAUSE back to IDLE.
    btn_clr = 1'b1; cyc(6);
    btn_clr = 1'b0; cyc(8);
    check("clr_pause_digits", digits, 16'h0000);

    // Counting: 12 ticks, one every TICK_DIV cycles after entering RUN.
    btn_ss = 1'b1;
    wait_running(1'b1, lat);
    check("start_latency", lat, DEB + 3);
    btn_ss = 1'b0;
    n_upd = 0;
    for (int c = 1; c <= 12 * TICK_DIV; c++) begin
      cyc(1);
      if (upd === 1'b1) begin
        check("upd_position", c, TICK_DIV * (n_upd + 1));
        n_upd++;
      end
    end
    check("count_digits", digits, 16'h0012);
    check("count_upd_n", n_upd, 12);

    // Pause two cycles after a tick, stay frozen, resume two cycles before the next tick.
    wait_upd(20);
    btn_ss = 1'b1;
    wait_running(1'b0, lat);
    check("stop_latency", lat, DEB + 3);
    btn_ss = 1'b0;
    frozen = digits;
    check("paused_value", frozen, 16'h0014);
    cyc(40);
    check("frozen_digits", digits, frozen);
    btn_ss = 1'b1;
    wait_running(1'b1, lat);
    btn_ss = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      cyc(1);
      if (upd === 1'b1) begin lat = c; break; end
    end
    check("resume_gap", lat, TICK_DIV - 2);
    check("resume_digits", digits, 16'h0015);

    // Carry chain and overflow.
    wait_digits(16'h0999, 5000);
    wait_upd(TICK_DIV + 2);
    check("carry_1000", digits, 16'h1000);
    check("carry_ovf", ovf, 1'b0);
    wait_digits(16'h9999, 40000);
    wait_upd(TICK_DIV + 2);
    check("wrap_digits", digits, 16'h0000);
    check("wrap_ovf", ovf, 1'b1);
    wait_upd(TICK_DIV + 2);
    check("after_wrap_digits", digits, 16'h0001);
    check("sticky_ovf", ovf, 1'b1);

    // Clear ignored while running.
    btn_clr = 1'b1; cyc(6);
    btn_clr = 1'b0; cyc(8);
    check("clr_in_run_running", running, 1'b1);
    check("clr_in_run_ovf", ovf, 1'b1);

    // Stop, then both buttons together: clear wins.
    btn_ss = 1'b1; cyc(6);
    btn_ss = 1'b0; cyc(8);
    check("stopped", running, 1'b0);
    u0 = upd_cnt;
    btn_ss = 1'b1; btn_clr = 1'b1; cyc(6);
    btn_ss = 1'b0; btn_clr = 1'b0; cyc(8);
    check("both_digits", digits, 16'h0000);
    check("both_ovf", ovf, 1'b0);
    check("both_running", running, 1'b0);
    check("both_upd_n", upd_cnt - u0, 1);

    // Clear from 0000 in IDLE gives no update.
    u0 = upd_cnt;
    btn_clr = 1'b1; cyc(6);
    btn_clr = 1'b0; cyc(8);
    check("clr_zero_upd_n", upd_cnt - u0, 0);

    // Asynchronous reset mid-run.
    btn_ss = 1'b1; cyc(6);
    btn_ss = 1'b0; cyc(12);
    #2 rst = 1'b0;
    #1;
    check("midrst_digits", digits, 16'h0000);
    check("midrst_running", running, 1'b0);
    cyc(2);
    rst = 1'b1;
    u0 = upd_cnt;
    cyc(6);
    check("midrst_release_upd", upd_cnt - u0, 0);
    check("midrst_release_digits", digits, 16'h0000);

    // Randomized button activity against the model.
    for (int k = 0; k < 300; k++) begin
      btn_ss  = 1'($urandom_range(0, 1));
      btn_clr = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 8));
    end
    btn_ss = 1'b0; btn_clr = 1'b0;
    cyc(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
